// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC/request address registers, I-cache handshake FSM and IF/ID register.
// Optional one-entry skid buffer for responses that land during a stall: define FETCH_SKID_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_pc,
    input  logic        stall_if_id,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        inst_mem_resp,
    input  logic [31:0] inst_mem_rdata,
    output logic        inst_mem_read,
    output logic [31:0] inst_mem_address,
    output logic [31:0] pc_if_id,
    output logic [31:0] instr_if_id,
    output logic        valid_if_id
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
`ifdef FETCH_SKID_EN
        , HOLD
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] pc_if_id_q, pc_if_id_d;
    logic [31:0] instr_if_id_q, instr_if_id_d;
    logic        valid_if_id_q, valid_if_id_d;
    logic        load;
    logic [31:0] load_data;
    logic        stall_any;
`ifdef FETCH_SKID_EN
    logic [31:0] skid_q, skid_d;
`endif

    assign stall_any = stall_pc | stall_if_id;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        load       = 1'b0;
        load_data  = inst_mem_rdata;
`ifdef FETCH_SKID_EN
        skid_d     = skid_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (flush) begin
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                end
            end
            FETCH: begin
                if (flush) begin
                    pc_d = redirect_pc;
                    if (inst_mem_resp) req_addr_d = redirect_pc;
                    else               state_d    = DRAIN;
                end else if (inst_mem_resp) begin
                    if (!stall_any) begin
                        load       = 1'b1;
                        pc_d       = req_addr_q + 32'd4;
                        req_addr_d = req_addr_q + 32'd4;
                    end else begin
`ifdef FETCH_SKID_EN
                        skid_d  = inst_mem_rdata;
                        state_d = HOLD;
`endif
                    end
                end
            end
            DRAIN: begin
                // pc holds the pending redirect target while the old request drains
                if (flush) begin
                    pc_d = redirect_pc;
                    if (inst_mem_resp) begin
                        req_addr_d = redirect_pc;
                        state_d    = FETCH;
                    end
                end else if (inst_mem_resp) begin
                    req_addr_d = pc_q;
                    state_d    = FETCH;
                end
            end
`ifdef FETCH_SKID_EN
            HOLD: begin
                if (flush) begin
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                    skid_d     = '0;
                    state_d    = FETCH;
                end else if (!stall_any) begin
                    load       = 1'b1;
                    load_data  = skid_q;
                    pc_d       = req_addr_q + 32'd4;
                    req_addr_d = req_addr_q + 32'd4;
                    state_d    = FETCH;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_if_id_d    = pc_if_id_q;
        instr_if_id_d = instr_if_id_q;
        valid_if_id_d = valid_if_id_q;
        if (flush) begin
            valid_if_id_d = 1'b0;
        end else if (load) begin
            pc_if_id_d    = req_addr_q;
            instr_if_id_d = load_data;
            valid_if_id_d = 1'b1;
        end else if (!stall_if_id) begin
            valid_if_id_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            pc_if_id_q    <= '0;
            instr_if_id_q <= NOP;
            valid_if_id_q <= 1'b0;
`ifdef FETCH_SKID_EN
            skid_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            pc_if_id_q    <= pc_if_id_d;
            instr_if_id_q <= instr_if_id_d;
            valid_if_id_q <= valid_if_id_d;
`ifdef FETCH_SKID_EN
            skid_q        <= skid_d;
`endif
        end
    end

    assign inst_mem_read    = (state_q == FETCH) || (state_q == DRAIN);
    assign inst_mem_address = req_addr_q;
    assign pc_if_id         = pc_if_id_q;
    assign instr_if_id      = instr_if_id_q;
    assign valid_if_id      = valid_if_id_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level fetch model, variable-latency I-cache, directed and random phases.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0060;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_pc, stall_if_id, flush;
    logic [31:0] redirect_pc;
    logic        inst_mem_resp;
    logic [31:0] inst_mem_rdata;
    logic        inst_mem_read;
    logic [31:0] inst_mem_address;
    logic [31:0] pc_if_id, instr_if_id;
    logic        valid_if_id;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .flush(flush), .redirect_pc(redirect_pc), .inst_mem_resp(inst_mem_resp),
        .inst_mem_rdata(inst_mem_rdata), .inst_mem_read(inst_mem_read),
        .inst_mem_address(inst_mem_address), .pc_if_id(pc_if_id),
        .instr_if_id(instr_if_id), .valid_if_id(valid_if_id)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;
    bit junk_resp = 1'b0;
    int fixed_lat = 1;
    int lat = 1;
    int cnt = 0;

    // Model: started, current fetch address, outstanding discard with target, skid, IF/ID view
    bit          m_started, m_discard, m_skid_full, m_valid;
    logic [31:0] m_addr, m_target, m_skid_word, m_pc, m_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit exp_read();
        return m_started && !m_skid_full;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_discard = 0; m_skid_full = 0; m_valid = 0;
        m_addr = RST_PC; m_target = '0; m_skid_word = '0; m_pc = '0; m_instr = NOP;
    endtask

    task automatic model_edge(input bit fl, input logic [31:0] rd, input bit spc, input bit sif,
                              input bit rs, input logic [31:0] data);
        bit loaded;
        loaded = 0;
        if (!m_started) begin
            m_started = 1;
            if (fl) m_addr = rd;
        end else if (fl) begin
            if (exp_read() && !rs) begin
                m_discard = 1; m_target = rd;
            end else begin
                m_addr = rd; m_discard = 0; m_skid_full = 0;
            end
        end else if (m_discard) begin
            if (rs) begin m_addr = m_target; m_discard = 0; end
        end else if (m_skid_full) begin
            if (!spc && !sif) begin
                m_pc = m_addr; m_instr = m_skid_word; m_valid = 1; m_addr += 4;
                loaded = 1; m_skid_full = 0;
            end
        end else if (rs) begin
            if (!spc && !sif) begin
                m_pc = m_addr; m_instr = data; m_valid = 1; m_addr += 4; loaded = 1;
            end else begin
`ifdef FETCH_SKID_EN
                m_skid_full = 1; m_skid_word = data;
`endif
            end
        end
        if (fl || (!loaded && !sif)) m_valid = 0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check32("read", {31'b0, inst_mem_read}, {31'b0, exp_read()});
            check32("address", inst_mem_address, m_addr);
            check32("pc_if_id", pc_if_id, m_pc);
            check32("instr_if_id", instr_if_id, m_instr);
            check32("valid_if_id", {31'b0, valid_if_id}, {31'b0, m_valid});
        end
    end

    task automatic step(input bit fl, input logic [31:0] rd, input bit spc, input bit sif);
        bit rs;
        logic [31:0] data;
        @(negedge clk);
        rs = 0;
        data = $urandom;
        if (inst_mem_read) begin
            if (cnt == 0) lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
            cnt++;
            if (cnt >= lat) begin rs = 1; data = mem_word(inst_mem_address); end
        end else begin
            cnt = 0;
        end
        if (junk_resp) rs = 1;
        flush = fl; redirect_pc = rd; stall_pc = spc; stall_if_id = sif;
        inst_mem_resp = rs; inst_mem_rdata = data;
        @(posedge clk);
        model_edge(fl, rd, spc, sif, rs, data);
        if (rs) cnt = 0;
        #2;
    endtask

    task automatic idle_step();
        step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cnt = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 0; redirect_pc = '0; stall_pc = 0; stall_if_id = 0;
        inst_mem_resp = 0; inst_mem_rdata = '0;
        model_reset();
        cmp_en = 1'b1;
        do_reset();

        // Reset values and back-to-back hits from RESET_PC
        check32("rst_read", {31'b0, inst_mem_read}, 32'd0);
        check32("rst_addr", inst_mem_address, 32'h60);
        check32("rst_valid", {31'b0, valid_if_id}, 32'd0);
        check32("rst_instr", instr_if_id, NOP);
        check32("rst_pc_if_id", pc_if_id, 32'd0);
        fixed_lat = 1;
        idle_step();
        check32("first_read", {31'b0, inst_mem_read}, 32'd1);
        check32("first_addr", inst_mem_address, 32'h60);
        idle_step(); check32("hit0_pc", pc_if_id, 32'h60);
        check32("hit0_valid", {31'b0, valid_if_id}, 32'd1);
        check32("hit0_instr", instr_if_id, mem_word(32'h60));
        idle_step(); check32("hit1_pc", pc_if_id, 32'h64);
        idle_step(); check32("hit2_pc", pc_if_id, 32'h68);
        check32("hit2_addr", inst_mem_address, 32'h6C);

        // Five-cycle miss at 0x64
        do_reset();
        fixed_lat = 1;
        idle_step();
        idle_step();
        fixed_lat = 5;
        for (int i = 0; i < 4; i++) begin
            idle_step();
            check32("miss_addr", inst_mem_address, 32'h64);
            check32("miss_valid", {31'b0, valid_if_id}, 32'd0);
        end
        idle_step();
        check32("miss_done_pc", pc_if_id, 32'h64);
        check32("miss_done_valid", {31'b0, valid_if_id}, 32'd1);

        // Flush to 0x200 while a miss at 0x70 is outstanding
        fixed_lat = 1;
        idle_step();
        idle_step();
        fixed_lat = 4;
        idle_step();
        step(1'b1, 32'h200, 1'b0, 1'b0);
        check32("drain_addr", inst_mem_address, 32'h70);
        check32("drain_read", {31'b0, inst_mem_read}, 32'd1);
        check32("drain_valid", {31'b0, valid_if_id}, 32'd0);
        idle_step(); check32("drain_addr2", inst_mem_address, 32'h70);
        idle_step();
        check32("redir_addr", inst_mem_address, 32'h200);
        check32("drop_valid", {31'b0, valid_if_id}, 32'd0);
        fixed_lat = 1;
        idle_step();
        check32("redir_pc", pc_if_id, 32'h200);
        check32("redir_instr", instr_if_id, mem_word(32'h200));

        // Response coincident with a two-cycle IF/ID stall
        step(1'b0, 32'h0, 1'b0, 1'b1);
`ifdef FETCH_SKID_EN
        check32("stall_read", {31'b0, inst_mem_read}, 32'd0);
`else
        check32("stall_read", {31'b0, inst_mem_read}, 32'd1);
`endif
        check32("stall_addr", inst_mem_address, 32'h204);
        check32("stall_hold_pc", pc_if_id, 32'h200);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check32("stall_hold_valid", {31'b0, valid_if_id}, 32'd1);
        idle_step();
        check32("stall_load_pc", pc_if_id, 32'h204);
        check32("stall_load_instr", instr_if_id, mem_word(32'h204));

        // Flush wins over stall
        step(1'b1, 32'h300, 1'b0, 1'b1);
        check32("flush_stall_valid", {31'b0, valid_if_id}, 32'd0);
        check32("flush_stall_addr", inst_mem_address, 32'h300);
        idle_step(); check32("flush_stall_pc", pc_if_id, 32'h300);

        // Address wrap
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        check32("wrap_addr0", inst_mem_address, 32'hFFFF_FFFC);
        idle_step();
        check32("wrap_pc", pc_if_id, 32'hFFFF_FFFC);
        check32("wrap_addr", inst_mem_address, 32'h0);
        idle_step(); check32("wrap_pc0", pc_if_id, 32'h0);

        // Reset during an outstanding request; response in IDLE ignored
        fixed_lat = 6;
        idle_step();
        idle_step();
        #1 rst_n = 1'b0;
        model_reset();
        cnt = 0;
        #1 check32("midrst_read", {31'b0, inst_mem_read}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        junk_resp = 1'b1;
        idle_step();
        junk_resp = 1'b0;
        check32("idle_resp_valid", {31'b0, valid_if_id}, 32'd0);
        check32("idle_resp_addr", inst_mem_address, 32'h60);

        // Random traffic
        fixed_lat = 0;
        for (int i = 0; i < 3000; i++) begin
            bit fl, spc, sif;
            logic [31:0] rd;
            fl  = ($urandom_range(0, 11) == 0);
            spc = ($urandom_range(0, 4) == 0);
            sif = ($urandom_range(0, 4) == 0);
            rd  = $urandom & 32'hFFFF_FFFC;
            step(fl, rd, spc, sif);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
